// File: rtl/gray_stream_decoder.sv
// gray_stream_decoder
//   Accepts a stream of Gray-coded samples, decodes each one to binary and
//   classifies the step from the previously accepted sample as up (+1),
//   down (-1) or error (anything else, including a repeat). The result is
//   held in a single output register. A saturating 8-bit counter tallies
//   step errors.
//
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1.
//   The producer holds its data stable while valid=1 and ready=0. in_ready
//   depends only on the output register state and out_ready, never on
//   in_valid.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   g_in       Gray-coded sample
//   in_valid   g_in is valid
//   in_ready   block can take a sample this cycle
//   b_out      decoded binary value
//   dir_up     step was +1 mod 2^WIDTH
//   dir_dn     step was -1 mod 2^WIDTH
//   step_err   step was neither +1 nor -1
//   out_valid  b_out and the flags are valid
//   out_ready  downstream accepts the output
//   err_count  saturating count of step errors
//   clr_err    synchronous clear of err_count
//   dbg_state  tracker state (0 = EMPTY, 1 = TRACK)
module gray_stream_decoder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] g_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] b_out,
  output logic             dir_up,
  output logic             dir_dn,
  output logic             step_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       err_count,
  input  logic             clr_err,
  output logic             dbg_state
);

  typedef enum logic {
    EMPTY = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] STEP_UP = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] STEP_DN = {WIDTH{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_b_q, prev_b_d;
  logic [WIDTH-1:0] b_out_q, b_out_d;
  logic             dir_up_q, dir_up_d;
  logic             dir_dn_q, dir_dn_d;
  logic             step_err_q, step_err_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       err_count_q, err_count_d;

  logic             accept;
  logic [WIDTH-1:0] b_new;
  logic [WIDTH-1:0] diff;
  logic             up_c, dn_c, err_c;

  // Ready whenever the output slot is empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Gray to binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b_new = '0;
    b_new[WIDTH-1] = g_in[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b_new[i] = b_new[i+1] ^ g_in[i];
    end
  end

  // Step classification; modular subtraction makes the wrap cases fall out
  // naturally (max -> 0 is +1, 0 -> max is -1).
  always_comb begin
    diff  = b_new - prev_b_q;
    up_c  = 1'b0;
    dn_c  = 1'b0;
    err_c = 1'b0;
    if (state_q == TRACK) begin
      if (diff == STEP_UP) begin
        up_c = 1'b1;
      end else if (diff == STEP_DN) begin
        dn_c = 1'b1;
      end else begin
        err_c = 1'b1;
      end
    end
  end

  // Tracker FSM and output register next-state.
  always_comb begin
    state_d     = state_q;
    prev_b_d    = prev_b_q;
    b_out_d     = b_out_q;
    dir_up_d    = dir_up_q;
    dir_dn_d    = dir_dn_q;
    step_err_d  = step_err_q;
    out_valid_d = out_valid_q;
    err_count_d = err_count_q;

    if (accept) begin
      state_d     = TRACK;
      prev_b_d    = b_new;
      b_out_d     = b_new;
      dir_up_d    = up_c;
      dir_dn_d    = dn_c;
      step_err_d  = err_c;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A clear coincident with an error leaves the new error counted.
    if (accept && err_c) begin
      if (clr_err) begin
        err_count_d = 8'd1;
      end else if (err_count_q != 8'hff) begin
        err_count_d = err_count_q + 8'd1;
      end
    end else if (clr_err) begin
      err_count_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      prev_b_q    <= '0;
      b_out_q     <= '0;
      dir_up_q    <= 1'b0;
      dir_dn_q    <= 1'b0;
      step_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      prev_b_q    <= prev_b_d;
      b_out_q     <= b_out_d;
      dir_up_q    <= dir_up_d;
      dir_dn_q    <= dir_dn_d;
      step_err_q  <= step_err_d;
      out_valid_q <= out_valid_d;
      err_count_q <= err_count_d;
    end
  end

  assign b_out     = b_out_q;
  assign dir_up    = dir_up_q;
  assign dir_dn    = dir_dn_q;
  assign step_err  = step_err_q;
  assign out_valid = out_valid_q;
  assign err_count = err_count_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gray_stream_decoder.sv
module tb_gray_stream_decoder;

  localparam int W = 4;
  // Expected flag encodings {dir_up, dir_dn, step_err}
  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_UP   = 3'b100;
  localparam logic [2:0] F_DN   = 3'b010;
  localparam logic [2:0] F_ERR  = 3'b001;

  logic         clk;
  logic         rst;
  logic [W-1:0] g_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] b_out;
  logic         dir_up;
  logic         dir_dn;
  logic         step_err;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   err_count;
  logic         clr_err;
  logic         dbg_state;

  int n_cmp;
  int n_bad;

  logic [W+2:0] exp_q[$];

  gray_stream_decoder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .g_in      (g_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .b_out     (b_out),
    .dir_up    (dir_up),
    .dir_dn    (dir_dn),
    .step_err  (step_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_count (err_count),
    .clr_err   (clr_err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] gray(input int b);
    logic [W-1:0] v;
    v = b[W-1:0];
    return v ^ (v >> 1);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the edge that accepted.
  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [W-1:0] g, input logic [W-1:0] eb,
                      input logic [2:0] ef);
    logic rdy;
    int   n;
    g_in     = g;
    in_valid = 1'b1;
    exp_q.push_back({eb, ef});
    n = 0;
    forever begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("b_out", int'(b_out), int'(e[W+2:3]));
        check("flags", int'({dir_up, dir_dn, step_err}), int'(e[2:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    g_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_err   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_b_out", b_out, 0);
    check("rst_flags", {dir_up, dir_dn, step_err}, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_state", dbg_state, 0);
    @(posedge clk);
    #1;

    // Up sweep 0..15 then 0 (wrap counts as up)
    send(gray(0), 4'd0, F_NONE);
    for (int i = 1; i <= 16; i++) send(gray(i % 16), W'(i % 16), F_UP);
    idle(2);
    check("up_err_count", err_count, 0);
    check("up_state", dbg_state, 1);

    // Down steps 3,2,1,0,15
    do_reset();
    send(4'b0010, 4'd3, F_NONE);
    send(4'b0011, 4'd2, F_DN);
    send(4'b0001, 4'd1, F_DN);
    send(4'b0000, 4'd0, F_DN);
    send(4'b1000, 4'd15, F_DN);
    idle(2);
    check("dn_err_count", err_count, 0);

    // Step error and repeated code
    do_reset();
    send(4'b0000, 4'd0, F_NONE);
    send(4'b0011, 4'd2, F_ERR);
    idle(1);
    check("err_count_1", err_count, 1);
    send(4'b0011, 4'd2, F_ERR);
    idle(1);
    check("err_count_2", err_count, 2);

    // Backpressure: output holds 3 while 4 waits; nothing lost
    out_ready = 1'b0;
    send(4'b0010, 4'd3, F_UP);
    fork
      send(4'b0110, 4'd4, F_UP);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
          check("bp_b_hold", b_out, 3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    send(4'b0111, 4'd5, F_UP);
    idle(2);
    check("bp_drained", exp_q.size(), 0);

    // Saturation and clear
    do_reset();
    send(4'b0000, 4'd0, F_NONE);
    for (int i = 0; i < 300; i++) send(4'b0000, 4'd0, F_ERR);
    idle(1);
    check("sat_255", err_count, 255);
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    @(negedge clk);
    check("clr_zero", err_count, 0);
    @(posedge clk);
    #1;
    clr_err = 1'b1;
    send(4'b0000, 4'd0, F_ERR);
    clr_err = 1'b0;
    @(negedge clk);
    check("clr_with_err", err_count, 1);
    @(posedge clk);
    #1;

    // Mid-stream reset discards held output; reset beats a same-cycle accept
    out_ready = 1'b0;
    send(4'b0100, 4'd7, F_ERR);
    @(negedge clk);
    check("mid_held_valid", out_valid, 1);
    @(posedge clk);
    #1;
    rst      = 1'b1;
    g_in     = 4'b1101;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_out_valid", out_valid, 0);
    check("mid_err_count", err_count, 0);
    check("mid_state", dbg_state, 0);
    check("mid_b_out", b_out, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'b0110, 4'd4, F_NONE);
    idle(2);
    check("final_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule
